serial_word_packer_fifo: RTL and testbench
==========================================

Name: serial_word_packer_fifo

Overview:
- Downstream consumer of the serial pattern generator's 1-bit `vector` stream.
- Deserialises qualified bits into WIDTH-bit words, MSB first, and buffers them in a DEPTH-entry first-word-fall-through FIFO for a word-wide reader.
- In the system, `bit_valid` is driven by the generator's `run` and `bit_in` by its `vector`.
- Provides occupancy flags, a count, and a sticky overflow indicator for verification and scoreboarding.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_valid  input  1  bit_in is sampled on this edge (connect to generator run).
- bit_in  input  1  serial data bit (connect to generator vector).
- rd_en  input  1  pop request; honoured only when empty=0.
- rd_data  output  WIDTH  head-of-FIFO word (FWFT); 0 when empty.
- empty  output  1  FIFO holds no words.
- full  output  1  FIFO holds DEPTH words.
- count  output  $clog2(DEPTH)+1  words currently stored.
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset:
  - rst_n=0 clears immediately, independent of clk: shift register, bit counter (bcnt), wr_ptr, rd_ptr, count, overflow.
  - Outputs under reset: empty=1, full=0, count=0, overflow=0, rd_data=0.
  - Memory contents need not be cleared.
  - Reset mid-word discards the partial word.
- Packer:
  - On an edge with bit_valid=1: sr <= {sr[WIDTH-2:0], bit_in}.
  - If bcnt==WIDTH-1: word {sr[WIDTH-2:0], bit_in} is complete and bcnt <= 0; otherwise bcnt <= bcnt+1.
  - The first bit received is the word MSB.
- Gaps: bit_valid=0 holds sr and bcnt indefinitely (no timeout, no flush).
- Push:
  - A completed word is written to mem[wr_ptr] on the same edge as its last bit, and wr_ptr increments (wraps modulo DEPTH).
  - If the FIFO is full and no pop occurs that edge, the word is dropped, overflow <= 1, and pointers are unchanged.
- Pop: rd_en=1 with empty=0 advances rd_ptr (wraps) at the edge; rd_en while empty is ignored, with no error flag.
- Simultaneous push and pop:
  - When not empty, both occur and count is unchanged.
  - When full, the pop frees the slot, the push succeeds, count stays DEPTH, and overflow is not set.
  - When empty, only the push occurs.
- Flags and count:
  - count is registered: +1 on push only, -1 on pop only.
  - empty = (count==0); full = (count==DEPTH).
  - The first word is visible on rd_data with empty=0 in the cycle after the edge that sampled its last bit (latency 1 cycle).
- rd_data is mem[rd_ptr] gated to 0 when empty; it updates the cycle after a pop.
- overflow clears only on reset.
- The packer keeps accepting bits while full; only the word-level push is dropped.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> empty=1, full=0, count=0, overflow=0, rd_data=8'h00.
- Single word: bit_valid=1, bits 1,0,1,1,0,0,1,0 over 8 edges -> one cycle after the 8th edge: empty=0, count=1, rd_data=8'hB2. rd_en one cycle -> empty=1, rd_data=8'h00.
- Gap mid-word: feed 4 bits 1,1,1,1, then bit_valid=0 for 5 cycles (count stays 0), then 4 bits 0,0,0,0 -> rd_data=8'hF0, count=1.
- Overflow: push words 8'h01, 8'h02, 8'h03, 8'h04 -> full=1, count=4. Push 8'h05 -> overflow=1, count=4. Read 4 times -> 01, 02, 03, 04, then empty=1; overflow stays 1.
- Push and pop at full: fill with 8'h11..8'h14, then complete 8'h15 on the same edge as rd_en=1 -> count=4, overflow=0. Subsequent reads -> 12, 13, 14, 15.
- Async reset mid-word: feed 3 bits, then drop rst_n between clock edges -> flags clear with no clock edge. Release and feed 8'hA5 -> rd_data=8'hA5, count=1.

Source files
------------

// File: rtl/serial_word_packer_fifo.sv
// Packs qualified serial bits MSB-first into WIDTH-bit words and buffers them in a FWFT FIFO.
// A word is readable one cycle after its last bit is sampled. When the FIFO is full and not popped, the word is dropped and sticky overflow is raised.
module serial_word_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);

  // Only WIDTH-1 history bits are needed; the incoming bit completes the word.
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]    bcnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] word_dat;
  logic             word_done;
  logic             pop;
  logic             push;

  assign word_dat  = {sr, bit_in};
  assign word_done = bit_valid && (bcnt == BW'(WIDTH-1));
  assign pop       = rd_en && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still succeeds.
  assign push      = word_done && (!full || pop);

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      bcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (bit_valid) begin
        sr   <= word_dat[WIDTH-2:0];
        bcnt <= word_done ? '0 : bcnt + BW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (word_done && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_dat;
  end

endmodule

// File: tb/tb_serial_word_packer_fifo.sv
// Directed bench for serial_word_packer_fifo with a queue-based reference model.
module tb_serial_word_packer_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             overflow;

  serial_word_packer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents plus packer state.
  logic [7:0] exp_q[$];
  logic [7:0] msr = '0;
  int         mbcnt = 0;
  logic       movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    msr   = '0;
    mbcnt = 0;
    movf  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, ".empty"},    32'(empty),    32'(exp_q.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
    chk({tag, ".count"},    32'(count),    32'(exp_q.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(head));
  endtask

  task automatic send_bit(input logic b, input logic do_rd);
    logic [7:0] tmp;
    bit_valid = 1'b1;
    bit_in    = b;
    rd_en     = do_rd;
    if (do_rd && exp_q.size() != 0) begin
      chk("pop_head", 32'(rd_data), 32'(exp_q[0]));
      tmp = exp_q.pop_front();
    end
    msr = {msr[6:0], b};
    if (mbcnt == WIDTH - 1) begin
      mbcnt = 0;
      if (exp_q.size() < DEPTH) exp_q.push_back(msr);
      else movf = 1'b1;
    end else begin
      mbcnt++;
    end
    tick();
    bit_valid = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rd_last);
    for (int i = 7; i >= 0; i--) send_bit(w[i], rd_last && (i == 0));
  endtask

  task automatic pop_word(input string tag);
    logic [7:0] tmp;
    chk({tag, ".head"}, 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    rd_en = 1'b1;
    if (exp_q.size() != 0) tmp = exp_q.pop_front();
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b2;
    // Reset
    do_reset();
    check_status("reset");

    // Single word 0xB2
    b2 = 8'hB2;
    send_word(b2, 1'b0);
    check_status("single");
    chk("single.value", 32'(rd_data), 32'hB2);
    pop_word("single_pop");
    check_status("single_after_pop");

    // Gap mid-word
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap.count", 32'(count), 32'd0);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    check_status("gap");
    chk("gap.value", 32'(rd_data), 32'hF0);
    pop_word("gap_pop");

    // Overflow
    for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0);
    check_status("fill");
    send_word(8'h05, 1'b0);
    check_status("overflow");
    chk("overflow.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pop_word("ovf_pop");
      check_status("ovf_drain");
    end
    pop_word("pop_empty");
    check_status("pop_empty");

    // Push and pop on the same edge while full
    do_reset();
    check_status("reset2");
    for (int w = 8'h11; w <= 8'h14; w++) send_word(8'(w), 1'b0);
    check_status("fill2");
    send_word(8'h15, 1'b1);
    check_status("push_pop_full");
    chk("push_pop_full.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pop_word("pp_drain");
      check_status("pp_drain");
    end

    // Asynchronous reset mid-word, with a word already stored
    send_word(8'h3C, 1'b0);
    check_status("pre_async");
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_status("async_reset");
    tick();
    rst_n = 1'b1;
    send_word(8'hA5, 1'b0);
    check_status("after_async");
    chk("after_async.value", 32'(rd_data), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
